// File: rtl/sa_input_vc_unit.sv
// Input-port half of the switch allocator: per-VC flit FIFOs, head-flit output VID capture,
// downstream credit tracking, and a registered crossbar output with upstream credit return.
module sa_input_vc_unit #(
    parameter int unsigned VID_BITS = 6,
    parameter int unsigned PORTS    = 5,
    parameter int unsigned CHANNELS = 12,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CREDITS  = 4,
    parameter int unsigned FLIT_W   = 34
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flit_in_valid,
    input  logic [$clog2(CHANNELS)-1:0]       flit_in_vc,
    input  logic [FLIT_W-1:0]                 flit_in,
    input  logic                              credit_in_valid,
    input  logic [VID_BITS-1:0]               credit_in_vid,
    output logic [CHANNELS-1:0]               sa_req,
    output logic [CHANNELS-1:0][VID_BITS-1:0] g_ovid,
    input  logic [CHANNELS-1:0]               sa_gnt,
    output logic                              flit_out_valid,
    output logic [FLIT_W-1:0]                 flit_out,
    output logic [VID_BITS-1:0]               flit_out_vid,
    output logic [CHANNELS-1:0]               credit_out,
    output logic [1:0]                        err
);
    localparam int unsigned NUM_OUT = PORTS * CHANNELS;
    localparam int unsigned VC_W    = $clog2(CHANNELS);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned CR_W    = $clog2(CREDITS + 1);

    typedef enum logic {StIdle, StActive} state_e;

    state_e                            state_q [CHANNELS];
    state_e                            state_d [CHANNELS];
    logic [CHANNELS-1:0][VID_BITS-1:0] ovid_q, ovid_d;
    logic [FLIT_W-1:0]                 mem_q [CHANNELS][DEPTH];
    logic [PTR_W-1:0]                  rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0]                  wr_ptr_q [CHANNELS];
    logic [CNT_W-1:0]                  count_q [CHANNELS];
    logic [CR_W-1:0]                   credit_q [NUM_OUT];
    logic [CR_W-1:0]                   credit_d [NUM_OUT];

    logic [CHANNELS-1:0][FLIT_W-1:0]   head;
    logic [CHANNELS-1:0]               disc, pop_gnt, pop, push;
    logic                              gnt_any, illegal, overflow;
    logic [VC_W-1:0]                   gnt_vc;

    assign g_ovid = ovid_q;

    // Requests, grant arbitration and head-of-line discards
    always_comb begin
        head    = '0;
        sa_req  = '0;
        disc    = '0;
        pop_gnt = '0;
        gnt_any = 1'b0;
        gnt_vc  = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            head[v]   = mem_q[v][rd_ptr_q[v]];
            sa_req[v] = (state_q[v] == StActive) && (count_q[v] != '0) &&
                        (32'(ovid_q[v]) < NUM_OUT) && (credit_q[ovid_q[v]] != '0);
            disc[v]   = (state_q[v] == StIdle) && (count_q[v] != '0) && !head[v][FLIT_W-2];
        end
        for (int v = 0; v < CHANNELS; v++) begin
            if (sa_gnt[v] && sa_req[v] && !gnt_any) begin
                gnt_any = 1'b1;
                gnt_vc  = VC_W'(v);
            end
        end
        if (gnt_any) pop_gnt[gnt_vc] = 1'b1;
        illegal = ((sa_gnt & (sa_gnt - CHANNELS'(1))) != '0) || ((sa_gnt & ~sa_req) != '0);
        pop     = pop_gnt | disc;
    end

    // Per-VC FSM, write acceptance and credit bookkeeping
    always_comb begin
        push     = '0;
        overflow = 1'b0;
        ovid_d   = ovid_q;
        for (int v = 0; v < CHANNELS; v++) begin
            state_d[v] = state_q[v];
            case (state_q[v])
                StIdle: begin
                    if (count_q[v] != '0 && head[v][FLIT_W-2]) begin
                        ovid_d[v]  = head[v][VID_BITS-1:0];
                        state_d[v] = StActive;
                    end
                end
                StActive: begin
                    if (pop_gnt[v] && head[v][FLIT_W-1]) state_d[v] = StIdle;
                end
            endcase
            // A full FIFO still accepts a write when it is popped in the same cycle
            if (flit_in_valid && flit_in_vc == VC_W'(v)) begin
                if (count_q[v] != CNT_W'(DEPTH) || pop[v]) push[v] = 1'b1;
                else overflow = 1'b1;
            end
        end
        for (int o = 0; o < NUM_OUT; o++) begin
            credit_d[o] = credit_q[o];
            if (credit_in_valid && credit_in_vid == VID_BITS'(o)) begin
                if (!(gnt_any && ovid_q[gnt_vc] == VID_BITS'(o)) && credit_q[o] != CR_W'(CREDITS))
                    credit_d[o] = credit_q[o] + CR_W'(1);
            end else if (gnt_any && ovid_q[gnt_vc] == VID_BITS'(o)) begin
                credit_d[o] = credit_q[o] - CR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < CHANNELS; v++) begin
            if (push[v]) mem_q[v][wr_ptr_q[v]] <= flit_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < CHANNELS; v++) begin
                state_q[v]  <= StIdle;
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            for (int o = 0; o < NUM_OUT; o++) credit_q[o] <= CR_W'(CREDITS);
            ovid_q         <= '0;
            flit_out_valid <= 1'b0;
            flit_out       <= '0;
            flit_out_vid   <= '0;
            credit_out     <= '0;
            err            <= '0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                state_q[v] <= state_d[v];
                if (push[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
                if (pop[v])  rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
                count_q[v] <= count_q[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
            end
            for (int o = 0; o < NUM_OUT; o++) credit_q[o] <= credit_d[o];
            ovid_q         <= ovid_d;
            flit_out_valid <= gnt_any;
            if (gnt_any) begin
                flit_out     <= head[gnt_vc];
                flit_out_vid <= ovid_q[gnt_vc];
            end
            // Discarded stray body/tail flits also free a slot, so upstream gets it back
            credit_out     <= pop;
            err            <= err | {illegal, overflow | (disc != '0)};
        end
    end
endmodule

// File: tb/tb_sa_input_vc_unit.sv
// Directed self-checking bench for sa_input_vc_unit: packet flow, credits, grants, overflow, reset.
module tb_sa_input_vc_unit;
    localparam int VID_BITS = 6;
    localparam int CHANNELS = 12;
    localparam int FLIT_W   = 34;
    localparam logic [1:0] HEAD = 2'b01, BODY = 2'b00, TAIL = 2'b10;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic                              flit_in_valid = 1'b0;
    logic [3:0]                        flit_in_vc = '0;
    logic [FLIT_W-1:0]                 flit_in = '0;
    logic                              credit_in_valid = 1'b0;
    logic [VID_BITS-1:0]               credit_in_vid = '0;
    logic [CHANNELS-1:0]               sa_req;
    logic [CHANNELS-1:0][VID_BITS-1:0] g_ovid;
    logic [CHANNELS-1:0]               sa_gnt = '0;
    logic                              flit_out_valid;
    logic [FLIT_W-1:0]                 flit_out;
    logic [VID_BITS-1:0]               flit_out_vid;
    logic [CHANNELS-1:0]               credit_out;
    logic [1:0]                        err;

    int checks = 0;
    int errors = 0;

    sa_input_vc_unit dut (
        .clk(clk), .rst(rst), .flit_in_valid(flit_in_valid), .flit_in_vc(flit_in_vc),
        .flit_in(flit_in), .credit_in_valid(credit_in_valid), .credit_in_vid(credit_in_vid),
        .sa_req(sa_req), .g_ovid(g_ovid), .sa_gnt(sa_gnt), .flit_out_valid(flit_out_valid),
        .flit_out(flit_out), .flit_out_vid(flit_out_vid), .credit_out(credit_out), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int unsigned pay,
                                              input logic [VID_BITS-1:0] vid);
        mk = {t, pay[25:0], vid};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given grant / write / credit inputs, then idle inputs
    task automatic drive_cycle(input logic [CHANNELS-1:0] g, input logic wv, input logic [3:0] wvc,
                               input logic [FLIT_W-1:0] f, input logic cv,
                               input logic [VID_BITS-1:0] cvid);
        sa_gnt = g; flit_in_valid = wv; flit_in_vc = wvc; flit_in = f;
        credit_in_valid = cv; credit_in_vid = cvid;
        step();
        sa_gnt = '0; flit_in_valid = 1'b0; credit_in_valid = 1'b0;
    endtask

    task automatic write(input logic [3:0] vc, input logic [FLIT_W-1:0] f);
        drive_cycle('0, 1'b1, vc, f, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0; sa_gnt = '0; flit_in_valid = 1'b0; credit_in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (sa_req !== '0) begin errors++; $display("FAIL rst_req got %h want 0", sa_req); end
        checks++; if (g_ovid !== '0) begin errors++; $display("FAIL rst_ovid got %h want 0", g_ovid); end
        checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", flit_out_valid); end
        checks++; if (flit_out !== '0 || flit_out_vid !== '0) begin errors++; $display("FAIL rst_flit got %h/%h want 0", flit_out, flit_out_vid); end
        checks++; if (credit_out !== '0) begin errors++; $display("FAIL rst_credit got %h want 0", credit_out); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", err); end
        step(); step();
        rst = 1'b1;
        step(); step();
        checks++; if (sa_req !== '0 || err !== 2'b00) begin errors++; $display("FAIL rst_idle got %h/%b want 0/00", sa_req, err); end
    endtask

    task automatic test_packet();
        logic [FLIT_W-1:0] exp_f [3];
        do_reset();
        exp_f[0] = mk(HEAD, 0, 7); exp_f[1] = mk(BODY, 1, 0); exp_f[2] = mk(TAIL, 2, 0);
        for (int i = 0; i < 3; i++) write(4'd3, exp_f[i]);
        checks++; if (sa_req !== 12'h008) begin errors++; $display("FAIL pkt_req got %h want 008", sa_req); end
        checks++; if (g_ovid[3] !== 6'd7) begin errors++; $display("FAIL pkt_ovid got %0d want 7", g_ovid[3]); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (sa_req[3] !== 1'b1) begin errors++; $display("FAIL pkt_req%0d got 0 want 1", i); end
            drive_cycle(12'h008, 1'b0, '0, '0, 1'b0, '0);
            checks++;
            if (flit_out_valid !== 1'b1 || flit_out_vid !== 6'd7 || flit_out !== exp_f[i]) begin
                errors++;
                $display("FAIL pkt_out%0d got %b/%0d/%h want 1/7/%h", i, flit_out_valid, flit_out_vid, flit_out, exp_f[i]);
            end
            checks++; if (credit_out !== 12'h008) begin errors++; $display("FAIL pkt_cred%0d got %h want 008", i, credit_out); end
        end
        checks++; if (sa_req !== '0) begin errors++; $display("FAIL pkt_idle got %h want 0", sa_req); end
        step();
        checks++; if (flit_out_valid !== 1'b0 || credit_out !== '0) begin errors++; $display("FAIL pkt_quiet got %b/%h want 0/0", flit_out_valid, credit_out); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL pkt_err got %b want 00", err); end
    endtask

    task automatic test_credit_exhaust();
        int pops = 0;
        logic [FLIT_W-1:0] last = '0;
        do_reset();
        write(4'd3, mk(HEAD, 0, 7));
        for (int i = 1; i < 4; i++) write(4'd3, mk(BODY, i, 0));
        for (int k = 0; k < 4; k++) begin
            checks++; if (sa_req[3] !== 1'b1) begin errors++; $display("FAIL cx_req%0d got 0 want 1", k); end
            drive_cycle(12'h008, k < 2, 4'd3, (k == 0) ? mk(BODY, 4, 0) : mk(TAIL, 5, 0), 1'b0, '0);
            if (flit_out_valid) begin pops++; last = flit_out; end
        end
        checks++; if (pops !== 4 || last !== mk(BODY, 3, 0)) begin errors++; $display("FAIL cx_pops got %0d/%h want 4/%h", pops, last, mk(BODY, 3, 0)); end
        checks++; if (sa_req[3] !== 1'b0) begin errors++; $display("FAIL cx_noreq got 1 want 0"); end
        step(); step();
        checks++; if (sa_req[3] !== 1'b0 || flit_out_valid !== 1'b0) begin errors++; $display("FAIL cx_stall got %b/%b want 0/0", sa_req[3], flit_out_valid); end
        drive_cycle('0, 1'b0, '0, '0, 1'b1, 6'd7);
        checks++; if (sa_req[3] !== 1'b1) begin errors++; $display("FAIL cx_refill got 0 want 1"); end
        drive_cycle(12'h008, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (flit_out_valid !== 1'b1 || flit_out !== mk(BODY, 4, 0)) begin errors++; $display("FAIL cx_fifth got %b/%h want 1/%h", flit_out_valid, flit_out, mk(BODY, 4, 0)); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL cx_err got %b want 00", err); end
    endtask

    task automatic test_multi_grant();
        do_reset();
        write(4'd0, mk(HEAD, 0, 10)); write(4'd0, mk(TAIL, 1, 0));
        write(4'd5, mk(HEAD, 0, 20)); write(4'd5, mk(TAIL, 1, 0));
        checks++; if (sa_req !== 12'h021) begin errors++; $display("FAIL mg_req got %h want 021", sa_req); end
        checks++; if (g_ovid[0] !== 6'd10 || g_ovid[5] !== 6'd20) begin errors++; $display("FAIL mg_ovid got %0d/%0d want 10/20", g_ovid[0], g_ovid[5]); end
        drive_cycle(12'h021, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (flit_out_vid !== 6'd10 || flit_out !== mk(HEAD, 0, 10)) begin errors++; $display("FAIL mg_out got %0d/%h want 10/%h", flit_out_vid, flit_out, mk(HEAD, 0, 10)); end
        checks++; if (credit_out !== 12'h001) begin errors++; $display("FAIL mg_cred got %h want 001", credit_out); end
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL mg_err got %b want 10", err); end
        drive_cycle(12'h020, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (flit_out !== mk(HEAD, 0, 20) || flit_out_vid !== 6'd20) begin errors++; $display("FAIL mg_vc5a got %h want %h", flit_out, mk(HEAD, 0, 20)); end
        drive_cycle(12'h020, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (flit_out !== mk(TAIL, 1, 0)) begin errors++; $display("FAIL mg_vc5b got %h want %h", flit_out, mk(TAIL, 1, 0)); end
        checks++; if (sa_req !== 12'h001) begin errors++; $display("FAIL mg_after got %h want 001", sa_req); end
    endtask

    task automatic test_overflow();
        int pops = 0;
        logic [FLIT_W-1:0] last = '0;
        do_reset();
        write(4'd2, mk(HEAD, 0, 3));
        for (int i = 1; i < 5; i++) write(4'd2, mk(BODY, i, 0));
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL ov_err got %b want 01", err); end
        for (int k = 0; k < 8; k++) begin
            if (!sa_req[2]) break;
            // Matching credit return keeps VID 3 topped up so only the FIFO limits the drain
            drive_cycle(12'h004, 1'b0, '0, '0, 1'b1, 6'd3);
            if (flit_out_valid) begin pops++; last = flit_out; end
        end
        checks++; if (pops !== 4 || last !== mk(BODY, 3, 0)) begin errors++; $display("FAIL ov_pops got %0d/%h want 4/%h", pops, last, mk(BODY, 3, 0)); end
        drive_cycle(12'h004, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (flit_out_valid !== 1'b0 || err !== 2'b11) begin errors++; $display("FAIL ov_badgnt got %b/%b want 0/11", flit_out_valid, err); end
    endtask

    task automatic test_credit_same_cycle();
        int pops = 0;
        do_reset();
        write(4'd1, mk(HEAD, 0, 9));
        for (int i = 1; i < 4; i++) write(4'd1, mk(BODY, i, 0));
        drive_cycle(12'h002, 1'b1, 4'd1, mk(BODY, 4, 0), 1'b0, '0);
        drive_cycle(12'h002, 1'b1, 4'd1, mk(BODY, 5, 0), 1'b0, '0);
        drive_cycle(12'h002, 1'b0, '0, '0, 1'b1, 6'd9);
        drive_cycle(12'h002, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (sa_req[1] !== 1'b1) begin errors++; $display("FAIL sc_one got 0 want 1"); end
        drive_cycle(12'h002, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (sa_req[1] !== 1'b0) begin errors++; $display("FAIL sc_zero got 1 want 0"); end
        for (int i = 0; i < 5; i++) drive_cycle('0, 1'b0, '0, '0, 1'b1, 6'd9);
        for (int k = 0; k < 10; k++) begin
            if (!sa_req[1]) break;
            drive_cycle(12'h002, 1'b1, 4'd1, mk(BODY, 10 + k, 0), 1'b0, '0);
            if (flit_out_valid) pops++;
        end
        checks++; if (pops !== 4) begin errors++; $display("FAIL sc_sat got %0d want 4", pops); end
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        do_reset();
        write(4'd4, mk(HEAD, 0, 7)); write(4'd4, mk(BODY, 1, 0)); write(4'd4, mk(BODY, 2, 0));
        drive_cycle(12'h010, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (flit_out_valid !== 1'b1 || sa_req !== 12'h010) begin errors++; $display("FAIL rm_pre got %b/%h want 1/010", flit_out_valid, sa_req); end
        rst = 1'b0;
        #1;
        checks++;
        if (sa_req !== '0 || g_ovid !== '0 || flit_out_valid !== 1'b0 || flit_out !== '0 ||
            flit_out_vid !== '0 || credit_out !== '0 || err !== 2'b00) begin
            errors++;
            $display("FAIL rm_outs got %h/%h/%b/%h/%h/%h/%b want all 0", sa_req, g_ovid, flit_out_valid, flit_out, flit_out_vid, credit_out, err);
        end
        step(); step();
        rst = 1'b1;
        step(); step(); step();
        checks++; if (sa_req !== '0 || err !== 2'b00 || credit_out !== '0) begin errors++; $display("FAIL rm_post got %h/%b/%h want 0/00/0", sa_req, err, credit_out); end
        write(4'd4, mk(HEAD, 0, 7));
        step();
        checks++; if (sa_req !== 12'h010) begin errors++; $display("FAIL rm_new got %h want 010", sa_req); end
        for (int k = 0; k < 10; k++) begin
            if (!sa_req[4]) break;
            drive_cycle(12'h010, 1'b1, 4'd4, mk(BODY, 20 + k, 0), 1'b0, '0);
            if (flit_out_valid) pops++;
        end
        checks++; if (pops !== 4) begin errors++; $display("FAIL rm_credits got %0d want 4", pops); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_packet();
        test_credit_exhaust();
        test_multi_grant();
        test_overflow();
        test_credit_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
